// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin writeback arbiter driving the register file write port
module reg_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [5*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0] req_data,
  output logic               rf_reg_write,
  output logic [4:0]         rf_write_reg,
  output logic [31:0]        rf_write_data,
  output logic [1:0]         rf_grant_id,
  input  logic [4:0]         hz_reg_1,
  input  logic [4:0]         hz_reg_2,
  output logic               hz_1,
  output logic               hz_2,
  output logic               idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_q [NREQ][DEPTH];
  logic [31:0]   data_q [NREQ][DEPTH];
  logic [AW-1:0] wptr_q [NREQ];
  logic [AW-1:0] rptr_q [NREQ];
  logic [CW-1:0] cnt_q  [NREQ];

  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_reg_q, rf_reg_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic [1:0]  rf_gid_q, rf_gid_d;

  logic [NREQ-1:0] empty, full, push, pop;
  logic            gnt_valid;
  logic [1:0]      gnt_id;
  logic [2:0]      scan_idx;
  logic [AW-1:0]   occ_off;
  logic            hz_raw_1, hz_raw_2;

  // FIFO status and requester handshake; ready looks at current occupancy only
  always_comb begin
    empty     = '0;
    full      = '0;
    req_ready = '0;
    push      = '0;
    for (int i = 0; i < NREQ; i++) begin
      empty[i]     = (cnt_q[i] == '0);
      full[i]      = (cnt_q[i] == CW'(DEPTH));
      req_ready[i] = ~full[i] & ~rst;
      push[i]      = req_valid[i] & req_ready[i];
    end
  end

  // Round-robin scan starting at rr_ptr; lowest offset with a queued entry wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + 3'(k);
      if (scan_idx >= 3'(NREQ)) begin
        scan_idx = scan_idx - 3'(NREQ);
      end
      if (!empty[scan_idx[1:0]]) begin
        gnt_valid = 1'b1;
        gnt_id    = scan_idx[1:0];
      end
    end
  end

  // Pop strobe for the granted FIFO
  always_comb begin
    pop = '0;
    for (int i = 0; i < NREQ; i++) begin
      pop[i] = gnt_valid && (gnt_id == 2'(i));
    end
  end

  // Next write-port contents; writes to r0 are consumed but never enabled
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rf_we_d   = 1'b0;
    rf_reg_d  = rf_reg_q;
    rf_data_d = rf_data_q;
    rf_gid_d  = rf_gid_q;
    if (gnt_valid) begin
      rr_ptr_d  = (gnt_id == 2'(NREQ - 1)) ? 2'd0 : gnt_id + 2'd1;
      rf_reg_d  = addr_q[gnt_id][rptr_q[gnt_id]];
      rf_data_d = data_q[gnt_id][rptr_q[gnt_id]];
      rf_gid_d  = gnt_id;
      rf_we_d   = (addr_q[gnt_id][rptr_q[gnt_id]] != 5'd0);
    end
  end

  // Control state: pointers, occupancy, scheduler pointer and write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_ptr_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_reg_q  <= '0;
      rf_data_q <= '0;
      rf_gid_q  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      rr_ptr_q  <= rr_ptr_d;
      rf_we_q   <= rf_we_d;
      rf_reg_q  <= rf_reg_d;
      rf_data_q <= rf_data_d;
      rf_gid_q  <= rf_gid_d;
    end
  end

  // FIFO payload storage; contents are meaningless outside the occupied window
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push[i]) begin
        addr_q[i][wptr_q[i]] <= req_addr[5*i +: 5];
        data_q[i][wptr_q[i]] <= req_data[32*i +: 32];
      end
    end
  end

  // Hazard match against every occupied FIFO slot and the committing write
  always_comb begin
    hz_raw_1 = 1'b0;
    hz_raw_2 = 1'b0;
    occ_off  = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        occ_off = AW'(j) - rptr_q[i];
        if ({1'b0, occ_off} < cnt_q[i]) begin
          if (addr_q[i][j] == hz_reg_1) hz_raw_1 = 1'b1;
          if (addr_q[i][j] == hz_reg_2) hz_raw_2 = 1'b1;
        end
      end
    end
    if (rf_we_q && (rf_reg_q == hz_reg_1)) hz_raw_1 = 1'b1;
    if (rf_we_q && (rf_reg_q == hz_reg_2)) hz_raw_2 = 1'b1;
  end

  assign hz_1          = hz_raw_1 & (hz_reg_1 != 5'd0) & ~rst;
  assign hz_2          = hz_raw_2 & (hz_reg_2 != 5'd0) & ~rst;
  assign idle          = (&empty) & ~rf_we_q;
  assign rf_reg_write  = rf_we_q;
  assign rf_write_reg  = rf_reg_q;
  assign rf_write_data = rf_data_q;
  assign rf_grant_id   = rf_gid_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;
  localparam int NREQ  = 3;
  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [5*NREQ-1:0]  req_addr;
  logic [32*NREQ-1:0] req_data;
  logic               rf_reg_write;
  logic [4:0]         rf_write_reg;
  logic [31:0]        rf_write_data;
  logic [1:0]         rf_grant_id;
  logic [4:0]         hz_reg_1, hz_reg_2;
  logic               hz_1, hz_2, idle;

  reg_wb_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .rf_grant_id(rf_grant_id),
    .hz_reg_1(hz_reg_1), .hz_reg_2(hz_reg_2),
    .hz_1(hz_1), .hz_2(hz_2), .idle(idle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // reference model: one queue of {addr,data} per requester plus the write port
  logic [36:0]     mq [NREQ][$];
  int              m_rr;
  logic            m_we;
  logic [4:0]      m_reg;
  logic [31:0]     m_data;
  logic [1:0]      m_gid;
  logic [NREQ-1:0] m_acc;

  logic [NREQ-1:0] cmp_rdy;
  logic            cmp_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   rdy [NREQ];
    int   g;
    logic [36:0] e;
    m_acc = '0;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) mq[i].delete();
      m_rr = 0; m_we = 1'b0; m_reg = '0; m_data = '0; m_gid = '0;
      return;
    end
    for (int i = 0; i < NREQ; i++) rdy[i] = (mq[i].size() < DEPTH);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && mq[(m_rr + k) % NREQ].size() > 0) g = (m_rr + k) % NREQ;
    end
    if (g >= 0) begin
      e      = mq[g].pop_front();
      m_reg  = e[36:32];
      m_data = e[31:0];
      m_we   = (e[36:32] != 5'd0);
      m_gid  = 2'(g);
      m_rr   = (g + 1) % NREQ;
    end else begin
      m_we = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && rdy[i]) begin
        m_acc[i] = 1'b1;
        mq[i].push_back({req_addr[5*i +: 5], req_data[32*i +: 32]});
      end
    end
  endtask

  function automatic logic m_hz(input logic [4:0] r);
    if (rst || r == 5'd0) return 1'b0;
    if (m_we && m_reg == r) return 1'b1;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < mq[i].size(); j++)
        if (mq[i][j][36:32] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_rand(input int pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i] || m_acc[i]) begin
        req_valid[i]          = (int'($urandom_range(0, 99)) < pct);
        req_addr[5*i +: 5]    = 5'($urandom_range(0, 7));
        req_data[32*i +: 32]  = $urandom;
      end
    end
    hz_reg_1 = 5'($urandom_range(0, 7));
    hz_reg_2 = 5'($urandom_range(0, 31));
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_idle = !m_we;
      for (int i = 0; i < NREQ; i++) begin
        cmp_rdy[i] = !rst && (mq[i].size() < DEPTH);
        if (mq[i].size() != 0) cmp_idle = 1'b0;
      end
      chk("req_ready", 32'(req_ready), 32'(cmp_rdy));
      chk("rf_reg_write", 32'(rf_reg_write), 32'(m_we));
      chk("rf_write_reg", 32'(rf_write_reg), 32'(m_reg));
      chk("rf_write_data", rf_write_data, m_data);
      chk("rf_grant_id", 32'(rf_grant_id), 32'(m_gid));
      chk("hz_1", 32'(hz_1), 32'(m_hz(hz_reg_1)));
      chk("hz_2", 32'(hz_2), 32'(m_hz(hz_reg_2)));
      chk("idle", 32'(idle), 32'(cmp_idle));
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    hz_reg_1 = '0; hz_reg_2 = '0;
    m_acc = '0; m_rr = 0; m_we = 1'b0; m_reg = '0; m_data = '0; m_gid = '0;
    tick();
    chk_en = 1'b1;
    chk("rst_we", 32'(rf_reg_write), 32'd0);
    chk("rst_wreg", 32'(rf_write_reg), 32'd0);
    chk("rst_wdata", rf_write_data, 32'd0);
    chk("rst_gid", 32'(rf_grant_id), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // single push: latency of two edges
    do_reset();
    req_valid = 3'b001; req_addr[4:0] = 5'd5; req_data[31:0] = 32'hDEADBEEF;
    tick();
    req_valid = '0;
    chk("t1_e1_we", 32'(rf_reg_write), 32'd0);
    chk("t1_e1_idle", 32'(idle), 32'd0);
    tick();
    chk("t1_e2_we", 32'(rf_reg_write), 32'd1);
    chk("t1_e2_wreg", 32'(rf_write_reg), 32'd5);
    chk("t1_e2_wdata", rf_write_data, 32'hDEADBEEF);
    chk("t1_e2_gid", 32'(rf_grant_id), 32'd0);
    chk("t1_e2_idle", 32'(idle), 32'd0);
    tick();
    chk("t1_e3_we", 32'(rf_reg_write), 32'd0);
    chk("t1_e3_idle", 32'(idle), 32'd1);

    // saturation: rotation, backpressure, then mid-operation reset
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[5*i +: 5]   = 5'(i + 1);
      req_data[32*i +: 32] = $urandom;
    end
    tick();
    for (int k = 2; k <= 12; k++) begin
      for (int i = 0; i < NREQ; i++) if (m_acc[i]) req_data[32*i +: 32] = $urandom;
      tick();
      chk("sat_gid", 32'(rf_grant_id), 32'((k - 2) % 3));
      chk("sat_we", 32'(rf_reg_write), 32'd1);
      if (k == 2) chk("sat_rdy_e2", 32'(req_ready), 32'b001);
      if (k == 3) chk("sat_rdy_e3", 32'(req_ready), 32'b010);
      if (k == 4) chk("sat_rdy_e4", 32'(req_ready), 32'b100);
    end
    hz_reg_1 = 5'd1; hz_reg_2 = 5'd2;
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(req_ready), 32'd0);
    chk("mrst_hz1", 32'(hz_1), 32'd0);
    chk("mrst_hz2", 32'(hz_2), 32'd0);
    tick();
    rst = 1'b0; req_valid = '0;
    #1;
    chk("mrst_after_we", 32'(rf_reg_write), 32'd0);
    chk("mrst_after_idle", 32'(idle), 32'd1);
    chk("mrst_after_hz1", 32'(hz_1), 32'd0);
    chk("mrst_after_hz2", 32'(hz_2), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_stale_we", 32'(rf_reg_write), 32'd0);
    end

    // register 0 entry is granted but not enabled
    do_reset();
    hz_reg_1 = 5'd0;
    req_valid = 3'b100; req_addr[14:10] = 5'd0; req_data[95:64] = 32'h1234;
    tick();
    req_valid = '0;
    chk("r0_e1_hz1", 32'(hz_1), 32'd0);
    tick();
    chk("r0_gid", 32'(rf_grant_id), 32'd2);
    chk("r0_we", 32'(rf_reg_write), 32'd0);
    chk("r0_wreg", 32'(rf_write_reg), 32'd0);
    chk("r0_wdata", rf_write_data, 32'h1234);
    chk("r0_hz1", 32'(hz_1), 32'd0);
    chk("r0_idle", 32'(idle), 32'd1);

    // hazard window on register 7
    do_reset();
    hz_reg_1 = 5'd7; hz_reg_2 = 5'd8;
    #1;
    chk("hz_pre", 32'(hz_1), 32'd0);
    req_valid = 3'b010; req_addr[9:5] = 5'd7; req_data[63:32] = $urandom;
    tick();
    req_valid = '0;
    chk("hz_e1_hz1", 32'(hz_1), 32'd1);
    chk("hz_e1_hz2", 32'(hz_2), 32'd0);
    tick();
    chk("hz_e2_hz1", 32'(hz_1), 32'd1);
    chk("hz_e2_we", 32'(rf_reg_write), 32'd1);
    tick();
    chk("hz_e3_hz1", 32'(hz_1), 32'd0);
    chk("hz_e3_hz2", 32'(hz_2), 32'd0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      drive_rand(((c / 500) % 2 == 1) ? 95 : 40);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
